// File: rtl/cpu_lsu_pkg.sv
`default_nettype none
// cpu_lsu_pkg: access-size encodings, FSM states and byte-lane helpers for the load/store unit.
// Rev 1.0
package cpu_lsu_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACCESS = 3'd1,
      ST_RMW_RD = 3'd2,
      ST_RMW_WR = 3'd3,
      ST_RESP   = 3'd4
   } state_t;

   function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] lane);
      logic [3:0] be;
      case (size)
         SIZE_B:  be = 4'b0001 << lane;
         SIZE_H:  be = 4'b0011 << lane;
         default: be = 4'hF;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_word,
                                         input logic [31:0] new_word,
                                         input logic [3:0]  be);
      logic [31:0] word;
      for (int b = 0; b < 4; b++) begin
         word[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
      end
      return word;
   endfunction

   // Size encoding 2'b11 behaves as a word access.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
      logic mis;
      case (size)
         SIZE_B:  mis = 1'b0;
         SIZE_H:  mis = lane[0];
         default: mis = |lane;
      endcase
      return mis;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_lsu_lane_align.sv
`default_nettype none
// lsu_lane_align: load extract/extend and store replicate/merge for one 32-bit bus word.
// Rev 1.0
module lsu_lane_align
   import cpu_lsu_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [1:0]  lane_i,
   input  logic [31:0] rdata_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] store_o,
   output logic [31:0] merged_o,
   output logic [3:0]  be_o
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = rdata_i[{lane_i, 3'b000} +: 8];
   assign w_half = rdata_i[{lane_i[1], 4'b0000} +: 16];

   always_comb begin
      load_o = rdata_i;
      case (size_i)
         SIZE_B:  load_o = {{24{w_byte[7] & ~unsigned_i}}, w_byte};
         SIZE_H:  load_o = {{16{w_half[15] & ~unsigned_i}}, w_half};
         default: load_o = rdata_i;
      endcase
   end

   always_comb begin
      store_o = wdata_i;
      case (size_i)
         SIZE_B:  store_o = {4{wdata_i[7:0]}};
         SIZE_H:  store_o = {2{wdata_i[15:0]}};
         default: store_o = wdata_i;
      endcase
   end

   assign be_o     = be_gen(size_i, lane_i);
   // The old word is the bus read data captured during the read half of a read-modify-write.
   assign merged_o = merge(rdata_i, store_o, be_o);

endmodule
`default_nettype wire

// File: rtl/cpu_lsu.sv
`default_nettype none
// cpu_lsu: load/store unit between the core datapath and a variable-latency req/ready bus.
// Rev 1.0
module cpu_lsu
   import cpu_lsu_pkg::*;
#(
   parameter int AW      = 32,
   parameter bit BYTE_EN = 1'b1,
   parameter int TIMEOUT = 255
) (
   input  logic          cpu_clk,
   input  logic          cpu_rst,
   input  logic          req_valid,
   input  logic          req_we,
   input  logic [1:0]    req_size,
   input  logic          req_unsigned,
   input  logic [AW-1:0] req_addr,
   input  logic [31:0]   req_wdata,
   output logic          req_ready,
   output logic          stall,
   output logic          rsp_valid,
   output logic [31:0]   rsp_rdata,
   output logic          misalign,
   output logic          bus_err,
   output logic          Bus_req,
   output logic [AW-1:0] Bus_addr,
   output logic          Bus_wen,
   output logic [31:0]   Bus_wdata,
   output logic [3:0]    Bus_be,
   input  logic          Bus_ready,
   input  logic [31:0]   Bus_rdata
);

   localparam int            CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [1:0]    size_q, size_d;
   logic          uns_q, uns_d;
   logic          we_q, we_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [31:0]   merged_q, merged_d;
   logic          mis_q, mis_d;
   logic          err_q, err_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [31:0]   w_load;
   logic [31:0]   w_store;
   logic [31:0]   w_merged;
   logic [3:0]    w_be;
   logic          w_timeout;
   logic          w_sub_store;

   lsu_lane_align u_align (
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .lane_i     (addr_q[1:0]),
      .rdata_i    (Bus_rdata),
      .wdata_i    (wdata_q),
      .load_o     (w_load),
      .store_o    (w_store),
      .merged_o   (w_merged),
      .be_o       (w_be)
   );

   always_ff @(posedge cpu_clk or negedge cpu_rst) begin
      if (!cpu_rst) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         size_q   <= SIZE_W;
         uns_q    <= 1'b0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         merged_q <= '0;
         mis_q    <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         size_q   <= size_d;
         uns_q    <= uns_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         merged_q <= merged_d;
         mis_q    <= mis_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   // A ready in the final counted cycle still wins over the timeout.
   assign w_timeout   = (TIMEOUT != 0) && (cnt_q == CNT_MAX);
   assign w_sub_store = req_we && ((req_size == SIZE_B) || (req_size == SIZE_H));

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      size_d   = size_q;
      uns_d    = uns_q;
      we_d     = we_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      merged_d = merged_q;
      mis_d    = mis_q;
      err_d    = err_q;
      cnt_d    = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               size_d  = req_size;
               uns_d   = req_unsigned;
               we_d    = req_we;
               wdata_d = req_wdata;
               rdata_d = '0;
               mis_d   = 1'b0;
               err_d   = 1'b0;
               cnt_d   = '0;
               if (misaligned(req_size, req_addr[1:0])) begin
                  mis_d   = 1'b1;
                  state_d = ST_RESP;
               end else if (!BYTE_EN && w_sub_store) begin
                  state_d = ST_RMW_RD;
               end else begin
                  state_d = ST_ACCESS;
               end
            end
         end

         ST_ACCESS: begin
            if (Bus_ready) begin
               if (!we_q) begin
                  rdata_d = w_load;
               end
               state_d = ST_RESP;
            end else if (w_timeout) begin
               err_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_RMW_RD: begin
            if (Bus_ready) begin
               merged_d = w_merged;
               cnt_d    = '0;
               state_d  = ST_RMW_WR;
            end else if (w_timeout) begin
               err_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_RMW_WR: begin
            if (Bus_ready) begin
               state_d = ST_RESP;
            end else if (w_timeout) begin
               err_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_RESP: state_d = ST_IDLE;

         default: state_d = ST_IDLE;
      endcase
   end

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign stall     = req_valid & ~rsp_valid;
   assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
   assign misalign  = rsp_valid & mis_q;
   assign bus_err   = rsp_valid & err_q;

   assign Bus_req   = (state_q == ST_ACCESS) || (state_q == ST_RMW_RD) || (state_q == ST_RMW_WR);
   assign Bus_addr  = {addr_q[AW-1:2], 2'b00};
   assign Bus_wen   = ((state_q == ST_ACCESS) && we_q) || (state_q == ST_RMW_WR);
   assign Bus_wdata = !Bus_wen ? 32'h0 : ((state_q == ST_RMW_WR) ? merged_q : w_store);

   generate
      if (BYTE_EN) begin : g_be_strobe
         assign Bus_be = Bus_wen ? w_be : 4'hF;
      end else begin : g_be_const
         assign Bus_be = 4'hF;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cpu_lsu.sv
`default_nettype none
// tb_cpu_lsu: scoreboard bench for cpu_lsu, one byte-strobe and one read-modify-write instance.
// Rev 1.0
`timescale 1ns/1ps
module tb_cpu_lsu;

   localparam int N    = 2;
   localparam int TMO  = 4;
   localparam int NDIR = 14;
   localparam int NOPS = 160;

   typedef struct {
      logic [31:0] rdata;
      bit          mis;
      bit          err;
      int          lat;
      int          reqc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic        req_valid    [N];
   logic        req_we       [N];
   logic [1:0]  req_size     [N];
   logic        req_unsigned [N];
   logic [31:0] req_addr     [N];
   logic [31:0] req_wdata    [N];
   logic        req_ready    [N];
   logic        stall        [N];
   logic        rsp_valid    [N];
   logic [31:0] rsp_rdata    [N];
   logic        misalign     [N];
   logic        bus_err      [N];
   logic        Bus_req      [N];
   logic [31:0] Bus_addr     [N];
   logic        Bus_wen      [N];
   logic [31:0] Bus_wdata    [N];
   logic [3:0]  Bus_be       [N];
   logic        Bus_ready    [N];
   logic [31:0] Bus_rdata    [N];

   cpu_lsu #(.AW(32), .BYTE_EN(1'b1), .TIMEOUT(TMO)) u_dut_be (
      .cpu_clk(clk), .cpu_rst(rst_n),
      .req_valid(req_valid[0]), .req_we(req_we[0]), .req_size(req_size[0]),
      .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .req_ready(req_ready[0]), .stall(stall[0]), .rsp_valid(rsp_valid[0]),
      .rsp_rdata(rsp_rdata[0]), .misalign(misalign[0]), .bus_err(bus_err[0]),
      .Bus_req(Bus_req[0]), .Bus_addr(Bus_addr[0]), .Bus_wen(Bus_wen[0]),
      .Bus_wdata(Bus_wdata[0]), .Bus_be(Bus_be[0]), .Bus_ready(Bus_ready[0]),
      .Bus_rdata(Bus_rdata[0])
   );

   cpu_lsu #(.AW(32), .BYTE_EN(1'b0), .TIMEOUT(TMO)) u_dut_rmw (
      .cpu_clk(clk), .cpu_rst(rst_n),
      .req_valid(req_valid[1]), .req_we(req_we[1]), .req_size(req_size[1]),
      .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .req_ready(req_ready[1]), .stall(stall[1]), .rsp_valid(rsp_valid[1]),
      .rsp_rdata(rsp_rdata[1]), .misalign(misalign[1]), .bus_err(bus_err[1]),
      .Bus_req(Bus_req[1]), .Bus_addr(Bus_addr[1]), .Bus_wen(Bus_wen[1]),
      .Bus_wdata(Bus_wdata[1]), .Bus_be(Bus_be[1]), .Bus_ready(Bus_ready[1]),
      .Bus_rdata(Bus_rdata[1])
   );

   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;
   exp_t        sb0[$];
   exp_t        sb1[$];
   logic [31:0] bus_mem [N][16];
   logic [31:0] ref_mem [N][16];
   int          bus_wait  [N];
   int          wait_left [N];
   bit          active    [N];
   int          acc_cyc   [N];
   int          reqc      [N];

   function automatic void check(string name, int i, logic [31:0] act, logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s dut%0d: actual %h required %h", name, i, act, req);
      end
   endfunction

   // Reference model: memory as plain words, sizes as byte counts, latency as phases x (waits+1).
   function automatic exp_t model(int i, bit we, logic [1:0] sz, bit uns,
                                  logic [31:0] addr, logic [31:0] wd, int w);
      exp_t   e;
      int     idx, lane, nb, ph, sh;
      longint word, val, lim;
      idx  = int'((addr - 32'h100) / 4);
      lane = int'(addr % 4);
      nb   = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
      e.rdata = 32'h0; e.mis = 1'b0; e.err = 1'b0; e.lat = 0; e.reqc = 0;
      if ((addr % nb) != 0) begin
         e.mis = 1'b1; e.lat = 1; e.reqc = 0;
         return e;
      end
      if (w >= TMO) begin
         e.err = 1'b1; e.lat = 1 + TMO; e.reqc = TMO;
         return e;
      end
      ph     = (we && i == 1 && nb < 4) ? 2 : 1;
      e.lat  = 1 + ph * (w + 1);
      e.reqc = ph * (w + 1);
      word   = longint'(ref_mem[i][idx]);
      if (we) begin
         for (int b = 0; b < nb; b++) begin
            sh   = 8 * (lane + b);
            word = word - (((word >> sh) % 256) << sh)
                        + (((longint'(wd) >> (8 * b)) % 256) << sh);
         end
         ref_mem[i][idx] = word[31:0];
      end else begin
         lim = longint'(1) << (8 * nb);
         val = (word >> (8 * lane)) % lim;
         if (!uns && nb < 4 && val >= lim / 2) val = val - lim;
         e.rdata = val[31:0];
      end
      return e;
   endfunction

   task automatic issue(int i, bit we, logic [1:0] sz, bit uns,
                        logic [31:0] addr, logic [31:0] wd, int w);
      exp_t e;
      e = model(i, we, sz, uns, addr, wd, w);
      if (i == 0) sb0.push_back(e); else sb1.push_back(e);
      bus_wait[i]     = w;
      req_we[i]       = we;
      req_size[i]     = sz;
      req_unsigned[i] = uns;
      req_addr[i]     = addr;
      req_wdata[i]    = wd;
      req_valid[i]    = 1'b1;
   endtask

   task automatic dir_op(int k, output bit we, output logic [1:0] sz, output bit uns,
                         output logic [31:0] addr, output logic [31:0] wd, output int w);
      we = 1'b0; sz = 2'd2; uns = 1'b0; addr = 32'h100; wd = 32'h0; w = 0;
      case (k)
         0:  begin addr = 32'h100; end
         1:  begin sz = 2'd0; addr = 32'h10B; end
         2:  begin sz = 2'd0; uns = 1'b1; addr = 32'h10B; end
         3:  begin sz = 2'd1; uns = 1'b1; addr = 32'h10E; w = 1; end
         4:  begin we = 1'b1; sz = 2'd1; addr = 32'h102; wd = 32'h0000_1234; end
         5:  begin addr = 32'h100; end
         6:  begin we = 1'b1; sz = 2'd0; addr = 32'h105; wd = 32'h0000_00AB; w = 2; end
         7:  begin addr = 32'h104; end
         8:  begin addr = 32'h102; end
         9:  begin addr = 32'h104; end
         10: begin addr = 32'h100; w = TMO - 1; end
         11: begin addr = 32'h100; w = 9; end
         12: begin we = 1'b1; sz = 2'd0; addr = 32'h10F; wd = 32'h77; w = 5; end
         default: begin sz = 2'd1; addr = 32'h10E; end
      endcase
   endtask

   task automatic next_op(int i, int k);
      bit          we, uns;
      logic [1:0]  sz;
      logic [31:0] addr, wd;
      int          w, r, nb;
      if (k < NDIR) begin
         dir_op(k, we, sz, uns, addr, wd, w);
      end else begin
         we   = 1'($urandom_range(0, 1));
         sz   = 2'($urandom_range(0, 3));
         uns  = 1'($urandom_range(0, 1));
         wd   = $urandom;
         addr = 32'h100 + $urandom_range(0, 63);
         nb   = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
         if ($urandom_range(0, 4) != 0) addr = addr - (addr % nb);
         r    = int'($urandom_range(0, 9));
         w    = (r < 8) ? (r % TMO) : (TMO + r % 3);
      end
      issue(i, we, sz, uns, addr, wd, w);
   endtask

   // Monitor/scoreboard plus bus responder; both act on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      bit   have;
      int   idx;
      cyc++;
      for (int i = 0; i < N; i++) begin
         if (!rst_n) begin
            Bus_ready[i] = 1'b0;
            active[i]    = 1'b0;
         end else begin
            check("stall", i, {31'b0, stall[i]}, {31'b0, req_valid[i] & ~rsp_valid[i]});
            if (i == 1) check("be_const", i, {28'b0, Bus_be[i]}, 32'hF);
            if (req_valid[i] && req_ready[i]) begin
               acc_cyc[i] = cyc;
               reqc[i]    = 0;
            end
            if (Bus_req[i]) begin
               reqc[i]++;
               check("bus_addr_lsb", i, {30'b0, Bus_addr[i][1:0]}, 32'h0);
            end
            if (rsp_valid[i]) begin
               have = (i == 0) ? (sb0.size() != 0) : (sb1.size() != 0);
               if (!have) begin
                  tests++;
                  fails++;
                  $display("FAIL rsp_unexpected dut%0d: actual rsp_valid=1 required no response", i);
               end else begin
                  e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
                  check("rdata", i, rsp_rdata[i], e.rdata);
                  check("misalign", i, {31'b0, misalign[i]}, {31'b0, e.mis});
                  check("bus_err", i, {31'b0, bus_err[i]}, {31'b0, e.err});
                  check("latency", i, cyc - acc_cyc[i], e.lat);
                  check("req_cycles", i, reqc[i], e.reqc);
               end
            end
            Bus_ready[i] = 1'b0;
            if (Bus_req[i]) begin
               if (!active[i]) begin
                  active[i]    = 1'b1;
                  wait_left[i] = bus_wait[i];
               end
               if (wait_left[i] == 0) begin
                  Bus_ready[i] = 1'b1;
                  active[i]    = 1'b0;
                  idx          = int'((Bus_addr[i] >> 2) % 16);
                  if (Bus_wen[i]) begin
                     for (int b = 0; b < 4; b++)
                        if (Bus_be[i][b]) bus_mem[i][idx][8*b +: 8] = Bus_wdata[i][8*b +: 8];
                  end else begin
                     Bus_rdata[i] = bus_mem[i][idx];
                  end
               end else begin
                  wait_left[i]--;
                  Bus_rdata[i] = $urandom;
               end
            end else begin
               active[i] = 1'b0;
            end
         end
      end
   end

   initial begin
      bit busy   [N];
      int issued [N];
      int age    [N];
      for (int i = 0; i < N; i++) begin
         req_valid[i] = 1'b0; req_we[i] = 1'b0; req_size[i] = 2'd0; req_unsigned[i] = 1'b0;
         req_addr[i] = 32'h0; req_wdata[i] = 32'h0; Bus_ready[i] = 1'b0; Bus_rdata[i] = 32'h0;
         bus_wait[i] = 0; wait_left[i] = 0; active[i] = 1'b0; acc_cyc[i] = 0; reqc[i] = 0;
         busy[i] = 1'b0; issued[i] = 0; age[i] = 0;
         for (int k = 0; k < 16; k++) bus_mem[i][k] = $urandom;
         bus_mem[i][0] = 32'hDEAD_BEEF;
         bus_mem[i][1] = 32'h1122_3344;
         bus_mem[i][2] = 32'h8000_0000;
         bus_mem[i][3] = 32'h8001_5555;
         for (int k = 0; k < 16; k++) ref_mem[i][k] = bus_mem[i][k];
      end

      #1 rst_n = 1'b0;
      #1;
      for (int i = 0; i < N; i++) begin
         check("rst_bus_req", i, {31'b0, Bus_req[i]}, 32'h0);
         check("rst_bus_wen", i, {31'b0, Bus_wen[i]}, 32'h0);
         check("rst_bus_be", i, {28'b0, Bus_be[i]}, 32'hF);
         check("rst_bus_wdata", i, Bus_wdata[i], 32'h0);
         check("rst_bus_addr", i, Bus_addr[i], 32'h0);
         check("rst_rsp_valid", i, {31'b0, rsp_valid[i]}, 32'h0);
         check("rst_rsp_rdata", i, rsp_rdata[i], 32'h0);
         check("rst_flags", i, {30'b0, misalign[i], bus_err[i]}, 32'h0);
         check("rst_stall", i, {31'b0, stall[i]}, 32'h0);
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int c = 0; c < 20000; c++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (busy[i]) begin
               if (rsp_valid[i]) begin
                  busy[i]      = 1'b0;
                  req_valid[i] = 1'b0;
               end else if (++age[i] > 100) begin
                  tests++;
                  fails++;
                  $display("FAIL op_timeout dut%0d: actual no rsp_valid after %0d cycles required response", i, age[i]);
                  busy[i]      = 1'b0;
                  req_valid[i] = 1'b0;
                  issued[i]    = NOPS;
               end
            end
            if (!busy[i] && issued[i] < NOPS) begin
               next_op(i, issued[i]);
               issued[i]++;
               busy[i] = 1'b1;
               age[i]  = 0;
            end
         end
         if (!busy[0] && !busy[1] && issued[0] >= NOPS && issued[1] >= NOPS) break;
      end
      for (int i = 0; i < N; i++) begin
         if (busy[i]) begin
            tests++;
            fails++;
            $display("FAIL run_budget dut%0d: actual ops still pending required all done", i);
            req_valid[i] = 1'b0;
         end
      end

      repeat (2) @(posedge clk);
      for (int i = 0; i < N; i++)
         for (int k = 0; k < 16; k++)
            check("final_mem", i, bus_mem[i][k], ref_mem[i][k]);

      // Reset while a load waits on a dead bus: the request must vanish with no response.
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) issue(i, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 50);
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) check("req_in_access", i, {31'b0, Bus_req[i]}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < N; i++) begin
         check("req_async_drop", i, {31'b0, Bus_req[i]}, 32'h0);
         check("rsp_in_reset", i, {31'b0, rsp_valid[i]}, 32'h0);
         req_valid[i] = 1'b0;
      end
      sb0.delete();
      sb1.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) check("idle_after_rst", i, {31'b0, req_ready[i]}, 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
